// File: rtl/game_ctrl.sv
// game_ctrl: game-flow scheduler between menu, map loader and play field.
// Sequences MENU -> LOAD -> PLAY -> OVER -> MENU, owns the round countdown,
// decides the winner and re-arms the menu with a one-cycle menu_rst pulse.
// Define PAUSE_EN to compile in the pause/resume state driven by p_press.
module game_ctrl #(
    parameter int unsigned TICK_DIV  = 25000000,
    parameter int unsigned ROUND_SEC = 180,
    parameter int unsigned OVER_SEC  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] start,
    input  logic       esc_press,
    input  logic       p_press,
    input  logic       load_done,
    input  logic       p1_dead,
    input  logic       p2_dead,
    output logic       menu_rst,
    output logic       load_req,
    output logic       map_sel,
    output logic       game_en,
    output logic [1:0] scene,
    output logic [7:0] time_left,
    output logic [1:0] winner,
    output logic       paused
);
    localparam int unsigned       TICK_W     = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [7:0]        ROUND_INIT = 8'(ROUND_SEC);
    localparam logic [7:0]        OVER_INIT  = 8'(OVER_SEC);

`ifdef PAUSE_EN
    typedef enum logic [2:0] {S_MENU, S_LOAD, S_PLAY, S_OVER, S_PAUSE} state_e;
`else
    typedef enum logic [1:0] {S_MENU, S_LOAD, S_PLAY, S_OVER} state_e;
`endif

    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [7:0]        time_q, time_d;
    logic [7:0]        over_q, over_d;
    logic [1:0]        winner_q, winner_d;
    logic              map_q, map_d;
    logic              menu_rst_q, menu_rst_d;
    logic              menu_dly_q;
    logic              esc_prev_q;
    logic [1:0]        scene_q, scene_d;
    logic              load_req_q, load_req_d;
    logic              game_en_q, game_en_d;
    logic              paused_q, paused_d;
    logic              esc_edge, tick_wrap, start_ok;

    assign esc_edge  = esc_press & ~esc_prev_q;
    assign tick_wrap = (tick_q == TICK_LAST);
    // start is only trusted once menu_rst has been low for a full cycle
    assign start_ok  = ~menu_rst_q & ~menu_dly_q;

`ifdef PAUSE_EN
    logic p_prev_q, p_edge;
    assign p_edge = p_press & ~p_prev_q;
`else
    logic unused_p_press;
    assign unused_p_press = p_press;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_MENU;
        else      state_q <= state_d;
    end

    // Next-state selection, exit priority in PLAY: deaths, timeout, esc, pause
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_MENU: if (start_ok && start[1]) state_d = S_LOAD;
            S_LOAD: if (load_done) state_d = S_PLAY;
            S_PLAY: begin
                if (p1_dead || p2_dead || time_q == '0) state_d = S_OVER;
                else if (esc_edge)                      state_d = S_MENU;
`ifdef PAUSE_EN
                else if (p_edge)                        state_d = S_PAUSE;
`endif
            end
            S_OVER: if (tick_wrap && over_q == 8'd1) state_d = S_MENU;
`ifdef PAUSE_EN
            S_PAUSE: begin
                if (esc_edge)    state_d = S_MENU;
                else if (p_edge) state_d = S_PLAY;
            end
`endif
            default: state_d = S_MENU;
        endcase
    end

    // Counters, winner and map latch updated on state transitions
    always_comb begin
        tick_d     = tick_q;
        time_d     = time_q;
        over_d     = over_q;
        winner_d   = winner_q;
        map_d      = map_q;
        menu_rst_d = 1'b0;
        case (state_q)
            S_MENU: if (state_d == S_LOAD) begin
                map_d    = start[0];
                winner_d = 2'b00;
            end
            S_LOAD: if (state_d == S_PLAY) begin
                time_d = ROUND_INIT;
                tick_d = '0;
            end
            S_PLAY: begin
                // the countdown still lands on the exit edge, so a death on the
                // final tick leaves time_left at 0 alongside the death verdict
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                if (tick_wrap && time_q != '0) time_d = time_q - 8'd1;
                if (p1_dead && p2_dead) winner_d = 2'b11;
                else if (p1_dead)       winner_d = 2'b10;
                else if (p2_dead)       winner_d = 2'b01;
                else if (time_q == '0)  winner_d = 2'b11;
                else if (esc_edge) begin
                    winner_d   = 2'b00;
                    menu_rst_d = 1'b1;
                end
`ifdef PAUSE_EN
                else if (p_edge) begin
                    tick_d = tick_q;
                    time_d = time_q;
                end
`endif
                if (state_d == S_OVER) begin
                    over_d = OVER_INIT;
                    tick_d = '0;
                end
            end
            S_OVER: begin
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                if (tick_wrap) over_d = over_q - 8'd1;
                if (state_d == S_MENU) menu_rst_d = 1'b1;
            end
`ifdef PAUSE_EN
            S_PAUSE: if (esc_edge) begin
                winner_d   = 2'b00;
                menu_rst_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Registered outputs derived from the state being entered
    always_comb begin
        case (state_d)
            S_MENU:  scene_d = 2'b00;
            S_LOAD:  scene_d = 2'b01;
            S_OVER:  scene_d = 2'b11;
            default: scene_d = 2'b10;
        endcase
        load_req_d = (state_d == S_LOAD);
        game_en_d  = (state_d == S_PLAY);
`ifdef PAUSE_EN
        paused_d   = (state_d == S_PAUSE);
`else
        paused_d   = 1'b0;
`endif
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q     <= '0;
            time_q     <= '0;
            over_q     <= '0;
            winner_q   <= '0;
            map_q      <= 1'b0;
            menu_rst_q <= 1'b1;
            menu_dly_q <= 1'b1;
            esc_prev_q <= 1'b1;
            scene_q    <= '0;
            load_req_q <= 1'b0;
            game_en_q  <= 1'b0;
            paused_q   <= 1'b0;
`ifdef PAUSE_EN
            p_prev_q   <= 1'b1;
`endif
        end else begin
            tick_q     <= tick_d;
            time_q     <= time_d;
            over_q     <= over_d;
            winner_q   <= winner_d;
            map_q      <= map_d;
            menu_rst_q <= menu_rst_d;
            menu_dly_q <= menu_rst_q;
            esc_prev_q <= esc_press;
            scene_q    <= scene_d;
            load_req_q <= load_req_d;
            game_en_q  <= game_en_d;
            paused_q   <= paused_d;
`ifdef PAUSE_EN
            p_prev_q   <= p_press;
`endif
        end
    end

    assign menu_rst  = menu_rst_q;
    assign load_req  = load_req_q;
    assign map_sel   = map_q;
    assign game_en   = game_en_q;
    assign scene     = scene_q;
    assign time_left = time_q;
    assign winner    = winner_q;
    assign paused    = paused_q;
endmodule
